// File: rtl/act_feeder_pkg.sv
// Shared types, geometry and row-walk helper for the activation row feeder.
// Optional stall counters are enabled with the ACT_FEEDER_STALL_CNT_EN macro (see act_feeder_row).
package act_feeder_pkg;

  localparam int N_ROW          = 6;
  localparam int WID_ACT        = 16;
  localparam int WID_BEAT       = 2 * WID_ACT;
  localparam int ROW_W          = $clog2(N_ROW);
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_WID_BEATS  = 8;
  localparam int DEF_WID_ROUNDS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_e;

  // Next enabled row strictly after ptr, wrapping modulo N_ROW; returns ptr when
  // it is the only enabled row. A result <= ptr means the walk wrapped.
  function automatic logic [ROW_W-1:0] next_en_row(input logic [N_ROW-1:0] mask,
                                                   input logic [ROW_W-1:0] ptr);
    logic [ROW_W-1:0] res;
    logic [ROW_W-1:0] cand;
    logic             found;
    int               idx;
    res   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_ROW; k++) begin
      idx  = (int'(ptr) + k) % N_ROW;
      cand = ROW_W'(idx);
      if (!found && mask[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/act_feeder_row_fifo.sv
// Per-row show-ahead FIFO: head word is always visible on o_data while o_empty is low.
// A push is accepted only when the FIFO is not full before any same-cycle pop.
module act_row_fifo
  import act_feeder_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = WID_BEAT
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/act_feeder_row.sv
// Splits one upstream activation stream into per-row bursts, walking enabled rows round-robin.
// Define ACT_FEEDER_STALL_CNT_EN to add per-row stall counters on the stall_cnt output.
//
// Handshakes: a beat moves on a channel in any cycle where its valid and its ready are both 1
// at the clock edge; valid and data stay stable until that happens, and valid never waits on ready.
module act_feeder_row
  import act_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WID_BEATS  = DEF_WID_BEATS,
  parameter int WID_ROUNDS = DEF_WID_ROUNDS
) (
  input  logic                      clk_l,
  input  logic                      rst_n,
  input  logic                      cfg_start,
  input  logic [WID_BEATS-1:0]      cfg_beats,
  input  logic [WID_ROUNDS-1:0]     cfg_rounds,
  input  logic [N_ROW-1:0]          cfg_row_mask,
  input  logic [WID_BEAT-1:0]       in_data,
  input  logic                      in_vld,
  output logic                      in_rdy,
  output logic [WID_BEAT*N_ROW-1:0] act_data_in,
  output logic [N_ROW-1:0]          act_data_in_vld,
  input  logic [N_ROW-1:0]          act_data_in_req,
  output logic                      busy,
  output fsm_e                      dbg_state,
`ifdef ACT_FEEDER_STALL_CNT_EN
  output logic [32*N_ROW-1:0]       stall_cnt,
`endif
  output logic                      done
);

  fsm_e                  r_state;
  logic [WID_BEATS-1:0]  r_beats;
  logic [WID_ROUNDS-1:0] r_rounds;
  logic [N_ROW-1:0]      r_mask;
  logic [ROW_W-1:0]      r_row_ptr;
  logic [WID_BEATS-1:0]  r_beat_cnt;
  logic [WID_ROUNDS-1:0] r_round_cnt;
  logic                  r_done;

  logic [N_ROW-1:0]      w_full;
  logic [N_ROW-1:0]      w_empty;
  logic [N_ROW-1:0]      w_push;
  logic                  w_up_fire;
  logic                  w_all_empty;
  logic                  w_degenerate;
  logic                  w_last_beat;
  logic                  w_wrap;
  logic [ROW_W-1:0]      w_next_row;

  // in_rdy only looks at registered state, so row-side req never reaches it combinationally.
  assign in_rdy       = (r_state == RUN) && !w_full[r_row_ptr];
  assign w_up_fire    = in_vld && in_rdy;
  assign w_all_empty  = &w_empty;
  assign w_next_row   = next_en_row(r_mask, r_row_ptr);
  assign w_last_beat  = (r_beat_cnt == r_beats - WID_BEATS'(1));
  assign w_wrap       = (w_next_row <= r_row_ptr);
  assign w_degenerate = (cfg_beats == '0) || (cfg_rounds == '0) || (cfg_row_mask == '0);

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    assign w_push[r]          = w_up_fire && (r_row_ptr == ROW_W'(r));
    assign act_data_in_vld[r] = !w_empty[r];

    act_row_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WID_BEAT)
    ) u_fifo (
      .clk_l   (clk_l),
      .rst_n   (rst_n),
      .i_push  (w_push[r]),
      .i_data  (in_data),
      .i_pop   (act_data_in_req[r]),
      .o_data  (act_data_in[r*WID_BEAT +: WID_BEAT]),
      .o_full  (w_full[r]),
      .o_empty (w_empty[r])
    );
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beats     <= '0;
      r_rounds    <= '0;
      r_mask      <= '0;
      r_row_ptr   <= '0;
      r_beat_cnt  <= '0;
      r_round_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_beats     <= cfg_beats;
            r_rounds    <= cfg_rounds;
            r_mask      <= cfg_row_mask;
            r_row_ptr   <= next_en_row(cfg_row_mask, ROW_W'(N_ROW - 1));
            r_beat_cnt  <= '0;
            r_round_cnt <= '0;
            r_state     <= w_degenerate ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (w_up_fire) begin
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              r_row_ptr  <= w_next_row;
              // Stepping back to a lower-or-equal row closes one round.
              if (w_wrap) begin
                if (r_round_cnt == r_rounds - WID_ROUNDS'(1)) r_state <= DRAIN;
                else r_round_cnt <= r_round_cnt + WID_ROUNDS'(1);
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + WID_BEATS'(1);
            end
          end
        end
        DRAIN: begin
          if (w_all_empty) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ACT_FEEDER_STALL_CNT_EN
  logic [31:0] r_stall [N_ROW];

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_ROW; r++) r_stall[r] <= '0;
    end else if (cfg_start && (r_state == IDLE)) begin
      for (int r = 0; r < N_ROW; r++) r_stall[r] <= '0;
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (act_data_in_vld[r] && !act_data_in_req[r] && (r_stall[r] != '1))
          r_stall[r] <= r_stall[r] + 32'd1;
      end
    end
  end

  for (genvar r = 0; r < N_ROW; r++) begin : g_stall
    assign stall_cnt[r*32 +: 32] = r_stall[r];
  end
`endif

endmodule
